// File: rtl/dlf_bw_scheduler.sv
// Bandwidth scheduler for the ADPLL loop filter: acquires lock WIDE -> MED -> NARROW,
// flushes the filter on (re)acquisition and reports lock, lock loss and fault.
module dlf_bw_scheduler #(
  parameter int ERR_WIDTH     = 8,
  parameter int CNT_WIDTH     = 10,
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 32,
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_COUNT  = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int FLUSH_CYCLES  = 4,
  parameter int ACQ_TIMEOUT   = 800,
  parameter int MAX_RETRY     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [ERR_WIDTH-1:0] err_mag,
  input  logic                 err_lead,
  output logic [1:0]           coeff_sel,
  output logic                 coeff_update,
  output logic                 dlf_clear,
  output logic                 locked,
  output logic                 lock_lost,
  output logic                 fault,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_WIDE   = 3'd2,
    S_MED    = 3'd3,
    S_NARROW = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [ERR_WIDTH-1:0] LOCK_T     = ERR_WIDTH'(LOCK_THRESH);
  localparam logic [ERR_WIDTH-1:0] UNLOCK_T   = ERR_WIDTH'(UNLOCK_THRESH);
  localparam logic [CNT_WIDTH-1:0] LOCK_C     = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] UNLOCK_C   = CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] SETTLE_C   = CNT_WIDTH'(SETTLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] FLUSH_LAST = CNT_WIDTH'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_C      = CNT_WIDTH'(ACQ_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] RETRY_C    = CNT_WIDTH'(MAX_RETRY);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   flush_q, flush_d;
  logic [CNT_WIDTH-1:0]   settle_q, settle_d;
  logic [CNT_WIDTH-1:0]   good_q, good_d;
  logic [CNT_WIDTH-1:0]   bad_q, bad_d;
  logic [CNT_WIDTH-1:0]   tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]   retry_q, retry_d;
  logic [1:0]             coeff_d;
  logic                   update_d;
  logic                   lost_d;
  logic                   advance;

  // Phase lead/lag is carried for observability only.
  logic unused_err_lead;
  assign unused_err_lead = err_lead;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    settle_d = settle_q;
    good_d   = good_q;
    bad_d    = bad_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    lost_d   = 1'b0;
    advance  = 1'b0;

    case (state_q)
      S_IDLE:  state_d = S_FLUSH;
      S_FLUSH: begin
        if (flush_q >= FLUSH_LAST) state_d = S_WIDE;
        else                       flush_d = sat_inc(flush_q);
      end
      S_WIDE, S_MED: begin
        tmo_d = sat_inc(tmo_q);
        if (settle_q < SETTLE_C) begin
          settle_d = sat_inc(settle_q);
        end else if (err_mag <= LOCK_T) begin
          if (sat_inc(good_q) >= LOCK_C) begin
            state_d = (state_q == S_WIDE) ? S_MED : S_NARROW;
            advance = 1'b1;
          end else begin
            good_d = sat_inc(good_q);
          end
        end else begin
          good_d = '0;
        end
        // A lock that completes on the timeout cycle is kept.
        if (!advance && (sat_inc(tmo_q) >= TMO_C)) begin
          if (retry_q >= RETRY_C) begin
            state_d = S_FAULT;
          end else begin
            retry_d = sat_inc(retry_q);
            state_d = S_FLUSH;
          end
        end
      end
      S_NARROW: begin
        if (err_mag > UNLOCK_T) begin
          if (sat_inc(bad_q) >= UNLOCK_C) begin
            state_d = S_FLUSH;
            lost_d  = 1'b1;
          end else begin
            bad_d = sat_inc(bad_q);
          end
        end else begin
          bad_d = '0;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      flush_d  = '0;
      settle_d = '0;
      good_d   = '0;
      bad_d    = '0;
    end
    if (state_d == S_FLUSH) tmo_d = '0;
    if ((state_d == S_NARROW) && (state_q != S_NARROW)) retry_d = '0;

    if (!enable) begin
      state_d  = S_IDLE;
      flush_d  = '0;
      settle_d = '0;
      good_d   = '0;
      bad_d    = '0;
      tmo_d    = '0;
      retry_d  = '0;
      lost_d   = 1'b0;
    end

    case (state_d)
      S_MED:    coeff_d = 2'b01;
      S_NARROW: coeff_d = 2'b10;
      default:  coeff_d = 2'b00;
    endcase
    // Disabling is a soft reset: no coefficient-change strobe goes to the filter.
    update_d = enable && (coeff_d != coeff_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      flush_q      <= '0;
      settle_q     <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      tmo_q        <= '0;
      retry_q      <= '0;
      coeff_sel    <= 2'b00;
      coeff_update <= 1'b0;
      dlf_clear    <= 1'b1;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      settle_q     <= settle_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      tmo_q        <= tmo_d;
      retry_q      <= retry_d;
      coeff_sel    <= coeff_d;
      coeff_update <= update_d;
      dlf_clear    <= (state_d == S_IDLE) || (state_d == S_FLUSH) || (state_d == S_FAULT);
      locked       <= (state_d == S_NARROW);
      lock_lost    <= lost_d;
      fault        <= (state_d == S_FAULT);
    end
  end

  assign state = state_q;

endmodule
